// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter draining a show-ahead FIFO, LSB first, fixed clock divider.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clock,
  input  logic       sclr,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          baud_last;

  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      fifo_rdreq <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      baud       <= '0;
      shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      fifo_rdreq <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state      <= S_LOAD;
            fifo_rdreq <= 1'b1;
            busy       <= 1'b1;
          end
        end
        // Show-ahead head is still valid on the edge that completes the pop.
        S_LOAD: begin
          shift_reg <= fifo_q;
`ifdef UART_TX_PARITY_EN
          par_bit   <= (^fifo_q) ^ 1'(PARITY_ODD);
`endif
          tx        <= 1'b0;
          baud      <= '0;
          state     <= S_START;
        end
        S_START: begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= shift_reg[0];
            state <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud      <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par_bit;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            baud <= baud + 1'b1;
            // Registered pulse lands in the final stop-bit clock.
            if (baud == BAUD_PRE) frame_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit engine that drains the 16-entry UART FIFO and serialises each byte onto the tx line as 8N1, LSB first.
- Sits directly downstream of the FIFO.
- Consumes the FIFO's show-ahead read data and drives its read request.
- Baud timing comes from a fixed clock-divider parameter.
- No external baud tick is needed.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd; ignored otherwise.

Ports:
clock  input  1  system clock; all logic on rising edge.
sclr  input  1  reset; asynchronous, active-low.
fifo_empty  input  1  FIFO empty flag.
fifo_q  input  8  FIFO head data; valid whenever fifo_empty=0 (show-ahead, no read latency).
fifo_rdreq  output  1  one-cycle pop strobe to FIFO.
tx  output  1  serial line; idle high.
busy  output  1  high from the pop cycle through the end of the stop bit.
frame_done  output  1  one-cycle pulse in the last clock of the stop bit.

Behaviour:
- Reset (sclr=0, async) sets: state=IDLE, tx=1, fifo_rdreq=0, busy=0, frame_done=0, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame: tx returns to 1 immediately; the byte in flight is discarded; the FIFO is not re-popped.
- All outputs are registered; tx has no combinational path from inputs.
- States: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1, busy=0. If fifo_empty=0, go to LOAD.
- LOAD (1 cycle):
  - fifo_rdreq=1 for exactly this cycle.
  - fifo_q is captured into the 8-bit shift register on the same edge (show-ahead data is valid before the pop).
  - busy=1.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, shift_reg[0] first, each held CLKS_PER_BIT cycles.
  - Shift right on each bit boundary.
  - A 3-bit counter counts 0..7; exit DATA after bit 7.
- STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in its final cycle; then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Cleared on entry to START.
- Frame timing without parity:
  - tx is low starting the edge after LOAD.
  - Frame = 10*CLKS_PER_BIT cycles.
- Back-to-back bytes:
  - IDLE takes exactly 1 cycle, then LOAD.
  - Gap from the end of STOP to the next start bit is 2 clocks (IDLE + LOAD), with tx=1 throughout.
- fifo_rdreq is never asserted while fifo_empty=1. At most one pop per frame.
- fifo_empty rising mid-frame has no effect on the current frame.
- The byte captured in LOAD is immune to later FIFO writes.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 captured bits, XORed with PARITY_ODD, held CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
  - Parity is computed from the byte at LOAD, not from the shifting register.
- Undefined:
  - No PARITY state exists and the state encoding omits it.
  - Frame = 10*CLKS_PER_BIT cycles.
  - PARITY_ODD is unused.

Test Plan:
1. Reset then idle, with sclr low 5 cycles, then high, fifo_empty=1 for 100 cycles -> tx=1, fifo_rdreq=0, busy=0 throughout.
2. Single byte, CLKS_PER_BIT=4, fifo_q=8'hA5, fifo_empty falls for 1 byte:
   - fifo_rdreq pulses exactly 1 cycle.
   - tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
   - frame_done pulses in cycle 40 after LOAD.
   - busy spans 41 cycles.
3. Back-to-back, CLKS_PER_BIT=4, FIFO holding 8'h00 then 8'hFF:
   - Exactly 2 rdreq pulses, 42 cycles apart.
   - Gap between the first stop end and the second start is 2 cycles high.
   - Second data bits are all 1.
4. Async reset mid-frame, sclr asserted between clock edges during DATA bit 3:
   - tx=1 in the same cycle, before the next edge.
   - After release with fifo_empty=1, no further rdreq.
   - After release with fifo_empty=0, a fresh frame starts via LOAD.
5. With UART_TX_PARITY_EN, PARITY_ODD=0, CLKS_PER_BIT=4, byte 8'h07:
   - Parity bit=1.
   - Frame 44 cycles.
   - frame_done at cycle 44 after LOAD.
   - Repeat with PARITY_ODD=1 -> parity bit=0.
6. Empty guard: toggle fifo_empty high for 1 cycle between frames, coinciding with the IDLE cycle -> no rdreq in that cycle; LOAD occurs on the first IDLE cycle with fifo_empty=0.
